// File: rtl/cube_pkg.sv
// Shared cube move encodings, move payload and FSM state type for the scramble path.
package cube_pkg;

  localparam int unsigned NUM_FACES = 6;
  localparam int unsigned FACE_W    = 3;
  localparam int unsigned DIR_W     = 2;
  localparam int unsigned IDX_W     = 6;

  localparam logic [FACE_W-1:0] FACE_U = 3'd0;
  localparam logic [FACE_W-1:0] FACE_D = 3'd1;
  localparam logic [FACE_W-1:0] FACE_L = 3'd2;
  localparam logic [FACE_W-1:0] FACE_R = 3'd3;
  localparam logic [FACE_W-1:0] FACE_F = 3'd4;
  localparam logic [FACE_W-1:0] FACE_B = 3'd5;

  localparam logic [DIR_W-1:0] DIR_CW  = 2'd0;
  localparam logic [DIR_W-1:0] DIR_CCW = 2'd1;
  localparam logic [DIR_W-1:0] DIR_DBL = 2'd2;

  // One stored move: face in the upper bits, turn direction in the lower bits.
  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [DIR_W-1:0]  dir;
  } move_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_F,
    S_SMP_F,
    S_REQ_D,
    S_SMP_D,
    S_STORE,
    S_EMIT,
    S_FIN
  } state_t;

  // Undoing a quarter turn needs the opposite quarter turn; a half turn undoes itself.
  function automatic logic [DIR_W-1:0] inv_dir(input logic [DIR_W-1:0] d);
    case (d)
      DIR_CW:  inv_dir = DIR_CCW;
      DIR_CCW: inv_dir = DIR_CW;
      default: inv_dir = d;
    endcase
  endfunction

endpackage

// File: rtl/scramble_buffer.sv
// LEN-entry move store: synchronous write, asynchronous read, indexed by move number.
module scramble_buffer
  import cube_pkg::*;
#(
  parameter int unsigned LEN = 20
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  move_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output move_t            rdata_c
);

  localparam int unsigned ADDR_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(LEN);

  move_t mem [LEN];

  // Write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH)) begin
      mem[ADDR_W'(waddr)] <= wdata;
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    rdata_c = '0;
    if (raddr < DEPTH) begin
      rdata_c = mem[ADDR_W'(raddr)];
    end
  end

endmodule

// File: rtl/scramble_sequencer.sv
// Builds a legal random scramble from generator draws, stores it, and streams it
// (or its inverse on replay) to the move engine over valid/ready.
module scramble_sequencer
  import cube_pkg::*;
#(
  parameter int unsigned LEN       = 20,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              replay,
  output logic              rand_req,
  input  logic [3:0]        rand_value,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [FACE_W-1:0] move_face,
  output logic [DIR_W-1:0]  move_dir,
  output logic [IDX_W-1:0]  move_index,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              seq_valid
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_t             state;
  logic [IDX_W-1:0]   widx;
  logic [RETRY_W-1:0] retry;
  logic [FACE_W-1:0]  cur_face;
  logic [DIR_W-1:0]   cur_dir;
  logic               reverse;

  logic               face_ok_c;
  logic               dir_ok_c;
  logic               retry_out_c;
  logic               buf_we_c;
  logic [IDX_W-1:0]   rd_addr_c;
  move_t              wr_move_c;
  move_t              rd_raw_c;
  move_t              rd_move_c;

  // Draw acceptance; cur_face still holds the previous move's face while sampling a new one.
  always_comb begin
    face_ok_c   = (rand_value < 4'(NUM_FACES)) &&
                  ((widx == '0) || (rand_value[FACE_W-1:0] != cur_face));
    dir_ok_c    = (rand_value <= 4'(DIR_DBL));
    retry_out_c = (retry == RETRY_LIM);
  end

  // Address of the move to present next: first/last entry on entry, else the following one.
  always_comb begin
    rd_addr_c = '0;
    case (state)
      S_IDLE:  rd_addr_c = LAST_IDX;
      S_STORE: rd_addr_c = '0;
      S_EMIT:  rd_addr_c = reverse ? (LAST_IDX - move_index - IDX_W'(1))
                                   : (move_index + IDX_W'(1));
      default: rd_addr_c = '0;
    endcase
  end

  // Write data, and bypass for the entry being written in the same cycle it is first read.
  always_comb begin
    buf_we_c  = (state == S_STORE);
    wr_move_c = '{face: cur_face, dir: cur_dir};
    rd_move_c = rd_raw_c;
    if (buf_we_c && (rd_addr_c == widx)) begin
      rd_move_c = wr_move_c;
    end
  end

  scramble_buffer #(
    .LEN (LEN)
  ) u_buffer (
    .clk     (clk),
    .we      (buf_we_c),
    .waddr   (widx),
    .wdata   (wr_move_c),
    .raddr   (rd_addr_c),
    .rdata_c (rd_raw_c)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      widx       <= '0;
      retry      <= '0;
      cur_face   <= '0;
      cur_dir    <= '0;
      reverse    <= 1'b0;
      rand_req   <= 1'b0;
      move_valid <= 1'b0;
      move_face  <= '0;
      move_dir   <= '0;
      move_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      seq_valid  <= 1'b0;
    end else begin
      rand_req <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ_F;
            rand_req  <= 1'b1;
            busy      <= 1'b1;
            error     <= 1'b0;
            seq_valid <= 1'b0;
            widx      <= '0;
            retry     <= '0;
          end else if (replay && seq_valid) begin
            state      <= S_EMIT;
            busy       <= 1'b1;
            reverse    <= 1'b1;
            move_valid <= 1'b1;
            move_index <= '0;
            move_face  <= rd_move_c.face;
            move_dir   <= inv_dir(rd_move_c.dir);
          end
        end
        S_REQ_F: state <= S_SMP_F;
        S_SMP_F: begin
          if (face_ok_c) begin
            cur_face <= rand_value[FACE_W-1:0];
            retry    <= '0;
            state    <= S_REQ_D;
            rand_req <= 1'b1;
          end else if (retry_out_c) begin
            error <= 1'b1;
            busy  <= 1'b0;
            retry <= '0;
            state <= S_IDLE;
          end else begin
            retry    <= retry + RETRY_W'(1);
            state    <= S_REQ_F;
            rand_req <= 1'b1;
          end
        end
        S_REQ_D: state <= S_SMP_D;
        S_SMP_D: begin
          if (dir_ok_c) begin
            cur_dir <= rand_value[DIR_W-1:0];
            retry   <= '0;
            state   <= S_STORE;
          end else if (retry_out_c) begin
            error <= 1'b1;
            busy  <= 1'b0;
            retry <= '0;
            state <= S_IDLE;
          end else begin
            retry    <= retry + RETRY_W'(1);
            state    <= S_REQ_D;
            rand_req <= 1'b1;
          end
        end
        S_STORE: begin
          if (widx != LAST_IDX) begin
            widx     <= widx + IDX_W'(1);
            state    <= S_REQ_F;
            rand_req <= 1'b1;
          end else begin
            seq_valid  <= 1'b1;
            reverse    <= 1'b0;
            move_valid <= 1'b1;
            move_index <= '0;
            move_face  <= rd_move_c.face;
            move_dir   <= rd_move_c.dir;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (move_ready) begin
            if (move_index == LAST_IDX) begin
              move_valid <= 1'b0;
              move_index <= '0;
              move_face  <= '0;
              move_dir   <= '0;
              done       <= 1'b1;
              state      <= S_FIN;
            end else begin
              move_index <= move_index + IDX_W'(1);
              move_face  <= rd_move_c.face;
              move_dir   <= reverse ? inv_dir(rd_move_c.dir) : rd_move_c.dir;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/scramble_sequencer.md
Name: scramble_sequencer

Overview:
- Consumes face/direction draws from the cube's random-number stage and builds a legal scramble of LEN moves.
- Rejects out-of-range draws and immediate same-face repeats, then stores the sequence in an internal buffer.
- Streams the moves over a valid/ready interface to the cube move engine.
- Can later replay the stored scramble as its inverse (reverse order, inverted turns), which is used to unscramble.

Parameters:
- LEN, 20: number of moves per scramble (1..63).
- MAX_RETRY, 15: maximum consecutive rejected draws allowed for one field before aborting.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins a new scramble (ignored unless idle)
- replay  input  1  pulse; emits the inverse of the stored scramble (ignored unless idle and seq_valid)
- rand_req  output  1  one-cycle draw request; drives the generator's button input
- rand_value  input  4  generator output; valid in the cycle after rand_req
- move_valid  output  1  move present on move_face/move_dir
- move_ready  input  1  downstream accepts the move
- move_face  output  3  0=U 1=D 2=L 3=R 4=F 5=B
- move_dir  output  2  0=CW 1=CCW 2=double
- move_index  output  6  index of the move currently presented (0-based, in emission order)
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse after the last move is accepted
- error  output  1  sticky retry-limit abort; cleared by the next accepted start or by reset
- seq_valid  output  1  a complete scramble is stored and replayable

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Buffer contents are don't-care.
- FSM states: IDLE, REQ_F, SMP_F, REQ_D, SMP_D, STORE, EMIT, FIN.
- IDLE:
  - start → REQ_F. Clears error, seq_valid and the move count.
  - replay with seq_valid=1 → EMIT in reverse mode.
  - start and replay in the same cycle: start wins.
- REQ_F/REQ_D: rand_req=1 for exactly one cycle, then go to SMP_F/SMP_D. A draw therefore takes 2 cycles.
- SMP_F:
  - Accept if rand_value<=5 and it differs from the previous move's face. The previous-face check does not apply to move 0.
  - Accepted face is latched and the retry count cleared → REQ_D.
  - Rejected draw increments the retry count → REQ_F.
- SMP_D:
  - Accept if rand_value<=2 → STORE; reject → REQ_D. Same retry rules as SMP_F.
- Retry limit: when the retry count reaches MAX_RETRY and the draw is rejected again (MAX_RETRY+1 rejects in total), set error=1 → IDLE. seq_valid stays 0 and no moves are emitted.
- STORE: writes {face,dir} at the write index.
  - Index < LEN-1: increment and go to REQ_F.
  - Otherwise set seq_valid=1 → EMIT in forward mode.
- EMIT (forward or reverse):
  - move_valid=1 with move_face/move_dir/move_index registered and held stable until a cycle with move_ready=1.
  - Transfer happens on the edge where valid&&ready. The next move is presented in the following cycle, so valid may stay high back-to-back.
  - Forward mode: buffer[0..LEN-1] as stored.
  - Reverse mode: buffer[LEN-1..0], with CW↔CCW swapped and double unchanged.
  - move_index counts 0..LEN-1 in emission order.
  - After the LEN-th transfer → FIN.
- FIN: done=1 for one cycle → IDLE. busy=1 through FIN.
- start/replay while busy are ignored, not queued.
- Reset mid-operation: immediate return to reset values. seq_valid=0, so a later replay is ignored until a new scramble completes.
- Upper rand_value bits above the range checks are ignored; generator values 6–15 are treated purely as rejects.

Decomposition:
- Package cube_pkg holds:
  - face encodings FACE_U..FACE_B and NUM_FACES=6;
  - direction encodings DIR_CW/DIR_CCW/DIR_DBL;
  - the move struct {face[2:0], dir[1:0]};
  - an inverse-direction function.
- One sub-module: scramble_buffer, an LEN×5-bit register file with a synchronous write port and an asynchronous read port, addressed by index.

Test Plan:
- LEN=4, bench model returns rand_value 2,0 | 2,5,1 | 0,4,2 | 1,0 with move_ready=1 → moves (2,0),(5,1),(0,2),(1,0). The repeat face 2 and dir 4 are rejected. move_index 0..3, done pulses once, seq_valid=1.
- Same run with move_ready low for 3 cycles during move 1 → move_valid stays 1 and face=5/dir=1 stay unchanged for all 3 cycles. Exactly 4 transfers occur.
- replay after the first scenario → (1,1),(0,2),(5,0),(2,1), then done. No rand_req is issued.
- MAX_RETRY=15, rand_value held at 6 → exactly 16 rand_req pulses, then error=1, busy=0, move_valid never asserts. A following start clears error.
- reset asserted during EMIT at move 2 → all outputs 0 asynchronously. A subsequent replay pulse is ignored (busy stays 0).
- start pulsed while busy → no effect on the sequence. start and replay in the same idle cycle → a new generation begins (rand_req pulses, seq_valid drops to 0).
